// File: rtl/image_link_pkg.sv
// Shared definitions for the UART pixel link (transmit and receive sides):
// link state encoding, per-pixel byte order and a coordinate helper.
package image_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OUTPUT,
        DONE
    } link_state_t;

    localparam int BYTES_PER_PIXEL = 5;

    localparam logic [2:0] BYTE_R = 3'd0;
    localparam logic [2:0] BYTE_G = 3'd1;
    localparam logic [2:0] BYTE_B = 3'd2;
    localparam logic [2:0] BYTE_H = 3'd3;
    localparam logic [2:0] BYTE_V = 3'd4;

    // Coordinate bytes on the link carry only the low 8 bits.
    function automatic logic [7:0] coord_lo(input logic [31:0] c);
        return c[7:0];
    endfunction

endpackage

// File: rtl/image_rx_timeout.sv
// Inter-byte timeout counter: cleared on load or when not running,
// raises tc for one cycle after TIMEOUT_CYCLES idle running cycles.
// Ports: clk, rst, load, run in; tc out (combinational strobe).
module image_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tc = run && !load && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || load || !run || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/image_receiver.sv
// UART pixel link receiver: rebuilds 5-byte R,G,B,H,V records into pixel
// writes with rdy/en frame handshake and sticky timeout/overrun/coord errors.
// Ports: clk, rst, en, rx_data/rx_valid, pix_ready in; rdy, pix_* ,
// frame_done, timeout_err, overrun_err, coord_err out.
// Define IMAGE_RX_COORD_CHECK_EN to compare H/V bytes against x/y.
module image_receiver
    import image_link_pkg::*;
#(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      rdy,
    input  logic                      en,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                pix_red,
    output logic [7:0]                pix_green,
    output logic [7:0]                pix_blue,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      frame_done,
    output logic                      timeout_err,
    output logic                      overrun_err,
    output logic                      coord_err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    link_state_t state;
    logic [2:0]  byte_idx;
    logic        hold_full;
    logic [7:0]  hold_data;

    logic tmo_load;
    logic tmo_run;
    logic tmo_tc;

    // Any byte taken into the record (held or fresh) restarts the timer.
    assign tmo_load = (state == COLLECT) && (hold_full || rx_valid);
    assign tmo_run  = (state == COLLECT) && (byte_idx != BYTE_R);

    image_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .load(tmo_load),
        .run (tmo_run),
        .tc  (tmo_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rdy         <= 1'b0;
            byte_idx    <= BYTE_R;
            hold_full   <= 1'b0;
            hold_data   <= '0;
            pix_red     <= '0;
            pix_green   <= '0;
            pix_blue    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            coord_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state       <= COLLECT;
                        rdy         <= 1'b0;
                        byte_idx    <= BYTE_R;
                        hold_full   <= 1'b0;
                        pix_x       <= '0;
                        pix_y       <= '0;
                        timeout_err <= 1'b0;
                        overrun_err <= 1'b0;
                        coord_err   <= 1'b0;
                    end else begin
                        rdy <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (hold_full) begin
                        // Held byte is always R; a same-cycle byte is G.
                        pix_red   <= hold_data;
                        hold_full <= 1'b0;
                        if (rx_valid) begin
                            pix_green <= rx_data;
                            byte_idx  <= BYTE_B;
                        end else begin
                            byte_idx  <= BYTE_G;
                        end
                    end else if (rx_valid) begin
                        case (byte_idx)
                            BYTE_R: pix_red   <= rx_data;
                            BYTE_G: pix_green <= rx_data;
                            BYTE_B: pix_blue  <= rx_data;
`ifdef IMAGE_RX_COORD_CHECK_EN
                            BYTE_H: begin
                                if (rx_data != coord_lo(32'(pix_x)))
                                    coord_err <= 1'b1;
                            end
                            BYTE_V: begin
                                if (rx_data != coord_lo(32'(pix_y)))
                                    coord_err <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                        if (byte_idx == BYTE_V) begin
                            state     <= OUTPUT;
                            pix_valid <= 1'b1;
                            byte_idx  <= BYTE_R;
                        end else begin
                            byte_idx  <= byte_idx + 3'd1;
                        end
                    end else if (tmo_tc) begin
                        // Drop the partial record; x/y stay put.
                        timeout_err <= 1'b1;
                        byte_idx    <= BYTE_R;
                    end
                end

                OUTPUT: begin
                    if (rx_valid) begin
                        if (hold_full) begin
                            overrun_err <= 1'b1;
                        end else begin
                            hold_data <= rx_data;
                            hold_full <= 1'b1;
                        end
                    end
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (pix_x == X_LAST) begin
                            pix_x <= '0;
                            if (pix_y == Y_LAST) begin
                                pix_y      <= '0;
                                state      <= DONE;
                                frame_done <= 1'b1;
                                hold_full  <= 1'b0;
                            end else begin
                                pix_y <= pix_y + 1'b1;
                                state <= COLLECT;
                            end
                        end else begin
                            pix_x <= pix_x + 1'b1;
                            state <= COLLECT;
                        end
                    end
                end

                DONE: begin
                    if (!en) begin
                        state      <= IDLE;
                        frame_done <= 1'b0;
                        rdy        <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_receiver.sv
// Self-checking bench for image_receiver on a 4x2 frame.
// Table of pixel records plus hand-written corner-case sequences.
module tb_image_receiver;

    localparam int W = 4;
    localparam int H = 2;
    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       pix_ready = 1'b1;

    logic       rdy;
    logic [7:0] pix_red;
    logic [7:0] pix_green;
    logic [7:0] pix_blue;
    logic [1:0] pix_x;
    logic [0:0] pix_y;
    logic       pix_valid;
    logic       frame_done;
    logic       timeout_err;
    logic       overrun_err;
    logic       coord_err;

    image_receiver #(
        .WIDTH(W),
        .HEIGHT(H),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .en         (en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pix_red    (pix_red),
        .pix_green  (pix_green),
        .pix_blue   (pix_blue),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .frame_done (frame_done),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err),
        .coord_err  (coord_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] h;
        logic [7:0] v;
        logic [1:0] x;
        logic [0:0] y;
    } rec_t;

    typedef struct packed {
        logic [1:0]  x;
        logic [0:0]  y;
        logic [23:0] rgb;
    } exp_t;

    rec_t tbl[8];
    rec_t crec;
    exp_t sb[$];
    exp_t got;
    int   tests = 0;
    int   fails = 0;
    logic exp_coord;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push(input rec_t r);
        sb.push_back({r.x, r.y, {r.r, r.g, r.b}});
    endtask

    task automatic send_rec(input rec_t r);
        push(r);
        send_byte(r.r, 1);
        send_byte(r.g, 1);
        send_byte(r.b, 1);
        send_byte(r.h, 1);
        send_byte(r.v, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!frame_done && n < 200) begin
            tick();
            n++;
        end
        check("frame_done", 32'(frame_done), 32'd1);
    endtask

    // Scoreboard: compare each accepted pixel against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && pix_valid && pix_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d required none",
                         pix_x, pix_y);
            end else begin
                got = sb.pop_front();
                check("pix_rgb", {8'h0, pix_red, pix_green, pix_blue},
                      {8'h0, got.rgb});
                check("pix_xy", 32'({pix_x, pix_y}), 32'({got.x, got.y}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef IMAGE_RX_COORD_CHECK_EN
        exp_coord = 1'b1;
`else
        exp_coord = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            tbl[i].r = 8'(8'h10 + i);
            tbl[i].g = 8'(8'h80 + 3 * i);
            tbl[i].b = 8'(8'hF0 - i);
            tbl[i].x = 2'(i % W);
            tbl[i].y = 1'(i / W);
            tbl[i].h = 8'(i % W);
            tbl[i].v = 8'(i / W);
        end

        // Reset state
        tick();
        tick();
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_errs", 32'({timeout_err, overrun_err, coord_err}), 32'd0);
        check("rst_pix", {pix_red, pix_green, pix_blue, 5'd0, pix_x, pix_y},
              32'd0);
        rst = 1'b0;
        tick();
        check("idle_rdy", 32'(rdy), 32'd1);

        // Clean frame
        en = 1'b1;
        tick();
        check("collect_rdy", 32'(rdy), 32'd0);
        for (int i = 0; i < 8; i++) send_rec(tbl[i]);
        wait_done();
        check("clean_errs", 32'({timeout_err, overrun_err, coord_err}), 32'd0);
        check("clean_sb", 32'(sb.size()), 32'd0);
        en = 1'b0;
        tick();
        check("done_idle_rdy", 32'(rdy), 32'd1);
        check("done_low", 32'(frame_done), 32'd0);

        // Backpressure with one byte held
        en = 1'b1;
        tick();
        send_rec(tbl[0]);
        send_rec(tbl[1]);
        push(tbl[2]);
        send_byte(tbl[2].r, 1);
        send_byte(tbl[2].g, 1);
        send_byte(tbl[2].b, 1);
        send_byte(tbl[2].h, 1);
        pix_ready = 1'b0;
        send_byte(tbl[2].v, 0);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 32'(pix_valid), 32'd1);
            check("bp_red", 32'(pix_red), 32'(tbl[2].r));
            check("bp_x", 32'(pix_x), 32'(tbl[2].x));
            if (c == 3) begin
                push(tbl[3]);
                send_byte(tbl[3].r, 0);
            end else begin
                tick();
            end
        end
        check("bp_overrun", 32'(overrun_err), 32'd0);
        pix_ready = 1'b1;
        tick();
        send_byte(tbl[3].g, 1);
        send_byte(tbl[3].b, 1);
        send_byte(tbl[3].h, 1);
        send_byte(tbl[3].v, 1);
        for (int i = 4; i < 8; i++) send_rec(tbl[i]);
        wait_done();
        check("bp_sb", 32'(sb.size()), 32'd0);
        check("bp_overrun_end", 32'(overrun_err), 32'd0);
        en = 1'b0;
        tick();
        tick();

        // Overrun: second byte while hold register full is lost
        en = 1'b1;
        tick();
        pix_ready = 1'b0;
        send_rec(tbl[0]);
        push(tbl[1]);
        send_byte(tbl[1].r, 1);
        send_byte(8'hEE, 1);
        check("ovr_err", 32'(overrun_err), 32'd1);
        pix_ready = 1'b1;
        tick();
        send_byte(tbl[1].g, 1);
        send_byte(tbl[1].b, 1);
        send_byte(tbl[1].h, 1);
        send_byte(tbl[1].v, 1);

        // Timeout on partial record at x=2
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        check("tmo_pre", 32'(timeout_err), 32'd0);
        repeat (60) tick();
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_x", 32'(pix_x), 32'd2);

        // Coordinate mismatch record still written at x=2
        crec.r = 8'h55;
        crec.g = 8'h66;
        crec.b = 8'h77;
        crec.h = 8'h07;
        crec.v = 8'h00;
        crec.x = 2'd2;
        crec.y = 1'd0;
        send_rec(crec);
        tick();
        check("coord_err", 32'(coord_err), 32'(exp_coord));
        check("coord_sb", 32'(sb.size()), 32'd0);

        // Reset mid-record
        en = 1'b0;
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_rdy0", 32'(rdy), 32'd0);
        tick();
        check("mrst_rdy1", 32'(rdy), 32'd1);
        check("mrst_valid", 32'(pix_valid), 32'd0);
        check("mrst_errs", 32'({timeout_err, overrun_err, coord_err}), 32'd0);
        check("mrst_x", 32'(pix_x), 32'd0);
        en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send_rec(tbl[i]);
        wait_done();
        check("mrst_sb", 32'(sb.size()), 32'd0);
        check("mrst_clean", 32'({timeout_err, overrun_err, coord_err}), 32'd0);
        en = 1'b0;
        tick();
        check("final_rdy", 32'(rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_receiver.md
# image_receiver

Receive side of the UART pixel link. It consumes the byte stream produced by the image transmitter: 5 bytes per pixel, in the order Red, Green, Blue, H byte, V byte. It reassembles each 5-byte record into a pixel write for the frame-buffer write port. It uses the same rdy/en frame handshake as the transmitter, and detects record timeouts, byte overruns and (optionally) coordinate mismatches.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- TIMEOUT_CYCLES, 1_000_000, maximum `clk` cycles allowed between bytes inside one record
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- rdy  out  1  high in IDLE: block can start a frame
- en  in  1  start/hold frame reception; sampled in IDLE and DONE
- rx_data  in  8  byte from the UART receiver
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- pix_red, pix_green, pix_blue  out  8 each  assembled colour
- pix_x  out  $clog2(WIDTH)  column of the current pixel
- pix_y  out  $clog2(HEIGHT)  row of the current pixel
- pix_valid  out  1  pixel word valid; held until accepted
- pix_ready  in  1  write port accepts the pixel on the cycle both pix_valid and pix_ready are high
- frame_done  out  1  high in DONE
- timeout_err, overrun_err, coord_err  out  1 each  sticky error flags; cleared in IDLE when en rises

## Operation
- States:
  - IDLE: rdy=1. On `en` → COLLECT. On entry, clear byte_idx, x, y and all error flags.
  - COLLECT: each rx_valid stores rx_data at byte_idx (0=R, 1=G, 2=B, 3=H, 4=V), then byte_idx increments. The byte at idx 4 → OUTPUT.
  - OUTPUT: pix_valid=1. On pix_ready, advance x/y:
    - If x==WIDTH-1: x←0, y←y+1.
    - If the accepted pixel is (WIDTH-1, HEIGHT-1) → DONE; otherwise → COLLECT with byte_idx=0.
  - DONE: frame_done=1. While en stays high, remain; when en=0 → IDLE.
- One-entry hold register:
  - A byte arriving in OUTPUT is stored in the hold register.
  - On return to COLLECT it is consumed as byte 0 in the first cycle, before any new rx_valid.
  - A byte arriving while the hold register is full sets overrun_err and is dropped.
  - If a new rx_valid arrives in the same cycle the hold register drains, the new byte is accepted as byte 1.
- rx_valid in IDLE or DONE is ignored without error.
- Timeout:
  - The counter resets on each accepted byte and runs only in COLLECT with byte_idx≠0.
  - On reaching TIMEOUT_CYCLES: set timeout_err, discard the partial record, byte_idx←0, x/y unchanged.
- Pixel count is implied by x/y; no separate down-counter.
- Coordinate bytes compare against the low 8 bits of x and y only; WIDTH/HEIGHT above 256 wrap the comparison naturally.
- en dropping mid-frame does not abort reception; the frame completes and en is rechecked in DONE.
- rst in any state → IDLE immediately; partial record and hold register discarded.

## Timing
- Reset values:
  - pix_valid, frame_done and all error flags: 0.
  - pix_red, pix_green, pix_blue, pix_x, pix_y: 0.
  - rdy is 0 during the rst cycle and 1 from the first cycle after.
- All outputs are registered.
- pix_valid rises the cycle after the 5th byte's rx_valid.
- pix_valid falls the cycle after the pix_valid&pix_ready handshake.
- Pixel data and coordinates are stable while pix_valid is high.
- Minimum record-to-record time: 5 bytes plus 1 handshake cycle.
- Error flags set on the cycle after the triggering event.

## Configuration
- Macro: IMAGE_RX_COORD_CHECK_EN.
- Defined:
  - The H/V bytes are compared against x[7:0]/y[7:0].
  - On mismatch: set coord_err and still write the pixel at the internal x/y.
- Undefined: H/V bytes are consumed but not compared; coord_err is tied to 0.

## Structure
- Shared package image_link_pkg:
  - state enum (IDLE, COLLECT, OUTPUT, DONE)
  - byte index constants BYTE_R..BYTE_V
  - BYTES_PER_PIXEL=5
  - the same package is used by the transmitter
- One natural sub-module: image_rx_timeout (loadable counter with a terminal-count strobe).

## Test plan
- Clean frame: WIDTH=4, HEIGHT=2, en=1, 8 records with correct H/V bytes, pix_ready=1 → 8 pixels (0,0)…(3,1) with matching RGB; frame_done after the last; no error flags.
- Backpressure: pix_ready=0 for 10 cycles on record 2 with one byte arriving meanwhile → pix_valid held, data stable; the held byte is used as R of record 3; overrun_err=0.
- Overrun: two bytes arrive while pix_ready=0 → overrun_err=1 and the second byte is lost.
- Timeout: TIMEOUT_CYCLES=50, send 3 bytes then idle 60 cycles → timeout_err=1; the next 5 bytes form a pixel at the unchanged x/y.
- Coordinate check (macro defined): record with H byte 0x07 at x=2 → coord_err=1 and the pixel is still written at x=2. With the macro undefined → coord_err=0.
- Reset mid-record: rst after 2 bytes → rdy=1 the next cycle; after en, a new frame starts at (0,0).
